// File: rtl/toy_fe_update_queue_pkg.sv
// Shared types and default sizing for the frontend BPU update queue.
package toy_fe_update_queue_pkg;

  typedef struct packed {
    logic [15:0] pc;
    logic [3:0]  br_type;
    logic [3:0]  tag;
  } be_pkg_t;

  localparam int FE_UPQ_CHNL_NUM = 4;
  localparam int FE_UPQ_DEPTH    = 16;
  localparam int FE_UPQ_RD_NUM   = 2;
  localparam int FE_UPQ_PLD_W    = $bits(be_pkg_t);

endpackage

// File: rtl/toy_fe_update_queue_if.sv
// Commit-side and drain-side handshake bundle of the update queue.
interface toy_fe_update_queue_if
  import toy_fe_update_queue_pkg::*;
#(
  parameter int CHNL_NUM  = FE_UPQ_CHNL_NUM,
  parameter int RD_NUM    = FE_UPQ_RD_NUM,
  parameter int PLD_WIDTH = FE_UPQ_PLD_W
);
  logic [CHNL_NUM-1:0]                in_vld;
  logic [CHNL_NUM-1:0]                in_last;
  logic [CHNL_NUM-1:0][PLD_WIDTH-1:0] in_pld;
  logic                               in_rdy;
  logic                               in_cancel;
  logic [RD_NUM-1:0]                  out_vld;
  logic [RD_NUM-1:0]                  out_rdy;
  logic [RD_NUM-1:0][PLD_WIDTH-1:0]   out_pld;
  logic [RD_NUM-1:0]                  out_cancel;

  modport master (
    output in_vld, in_last, in_pld, in_cancel, out_rdy,
    input  in_rdy, out_vld, out_pld, out_cancel
  );

  modport slave (
    input  in_vld, in_last, in_pld, in_cancel, out_rdy,
    output in_rdy, out_vld, out_pld, out_cancel
  );
endinterface

// File: rtl/toy_fe_update_queue_compact.sv
// Prefix-sum compaction: per-channel slot offset and total number of enqueued channels.
module toy_fe_upq_compact
  import toy_fe_update_queue_pkg::*;
#(
  parameter int CHNL_NUM = FE_UPQ_CHNL_NUM,
  parameter int OW       = $clog2(CHNL_NUM) + 1
) (
  input  logic [CHNL_NUM-1:0]         en_i,
  output logic [CHNL_NUM-1:0][OW-1:0] off_o,
  output logic [OW-1:0]               total_o
);
  logic [OW-1:0] run;

  // off_o[i] is the count of enabled channels below i, i.e. n[i]-1 when en_i[i]
  always_comb begin
    run   = '0;
    off_o = '0;
    for (int i = 0; i < CHNL_NUM; i++) begin
      off_o[i] = run;
      run      = run + OW'(en_i[i]);
    end
    total_o = run;
  end
endmodule

// File: rtl/toy_fe_update_queue.sv
// In-order commit-to-BPU update queue: compacting multi-channel push, multi-lane drain, cancel tagging.
module toy_fe_update_queue
  import toy_fe_update_queue_pkg::*;
#(
  parameter int CHNL_NUM  = FE_UPQ_CHNL_NUM,
  parameter int DEPTH     = FE_UPQ_DEPTH,
  parameter int RD_NUM    = FE_UPQ_RD_NUM,
  parameter int PLD_WIDTH = FE_UPQ_PLD_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o,
  toy_fe_update_queue_if.slave     bus_if
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(CHNL_NUM) + 1;
  localparam int CW = AW + 2;

  typedef logic [AW:0] ptr_t;

  ptr_t                  wr_q, wr_d, rd_q, rd_d, cnt, pop;
  logic [DEPTH-1:0]      canc_q, canc_d;
  logic                  pend_q, pend_d;
  logic [PLD_WIDTH-1:0]  mem_q [DEPTH];
  logic [CHNL_NUM-1:0]   en;
  logic [CHNL_NUM-1:0][OW-1:0] off;
  logic [OW-1:0]         total;
  logic                  push, empty, pop_run;

  function automatic logic [AW-1:0] idx(ptr_t p);
    return p[AW-1:0];
  endfunction

  assign en = bus_if.in_vld & bus_if.in_last;

  toy_fe_upq_compact #(.CHNL_NUM(CHNL_NUM), .OW(OW)) u_compact (
    .en_i    (en),
    .off_o   (off),
    .total_o (total)
  );

  assign cnt     = wr_q - rd_q;
  assign count_o = cnt;
  assign empty   = (wr_q == rd_q);
  // Room check uses registered occupancy only; a same-cycle pop gives no credit.
  assign bus_if.in_rdy = ({1'b0, cnt} + CW'(CHNL_NUM)) <= CW'(DEPTH);
  assign push          = bus_if.in_rdy && (|en) && !flush_i && !rst_i;

  for (genvar k = 0; k < RD_NUM; k++) begin : g_lane
    ptr_t rp;
    assign rp                   = rd_q + ptr_t'(k);
    assign bus_if.out_vld[k]    = cnt > ptr_t'(k);
    assign bus_if.out_pld[k]    = mem_q[idx(rp)];
    assign bus_if.out_cancel[k] = bus_if.out_vld[k] & canc_q[idx(rp)];
  end

  always_comb begin
    pop     = '0;
    pop_run = 1'b1;
    for (int k = 0; k < RD_NUM; k++) begin
      pop_run = pop_run & bus_if.out_vld[k] & bus_if.out_rdy[k];
      pop     = pop + ptr_t'(pop_run);
    end
  end

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q + pop;
    canc_d = canc_q;
    pend_d = pend_q;
    // A cancel with nothing to attach waits; it lands on the youngest resident if no push arrives.
    if (!push) begin
      if (pend_q && !empty) begin
        canc_d[idx(wr_q - ptr_t'(1))] = 1'b1;
        pend_d                        = 1'b0;
      end
      if (bus_if.in_cancel && total == '0) pend_d = 1'b1;
    end
    for (int k = 0; k < RD_NUM; k++)
      if (ptr_t'(k) < pop) canc_d[idx(rd_q + ptr_t'(k))] = 1'b0;
    if (push) begin
      for (int i = 0; i < CHNL_NUM; i++)
        if (en[i])
          canc_d[idx(wr_q + ptr_t'(off[i]))] = (off[i] == total - OW'(1)) &&
                                               (bus_if.in_cancel || pend_q);
      wr_d   = wr_q + ptr_t'(total);
      pend_d = 1'b0;
    end
    if (flush_i) begin
      wr_d   = '0;
      rd_d   = '0;
      canc_d = '0;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      canc_q <= '0;
      pend_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      canc_q <= canc_d;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push)
      for (int i = 0; i < CHNL_NUM; i++)
        if (en[i]) mem_q[idx(wr_q + ptr_t'(off[i]))] <= bus_if.in_pld[i];
  end

  a_rdy_prefix: assert property (@(posedge clk_i) disable iff (rst_i)
    (bus_if.out_rdy & (bus_if.out_rdy + RD_NUM'(1))) == '0);
  a_cnt_max: assert property (@(posedge clk_i) disable iff (rst_i)
    cnt <= ptr_t'(DEPTH));
  a_no_overwrite: assert property (@(posedge clk_i) disable iff (rst_i)
    push |-> ({1'b0, cnt} + CW'(total)) <= CW'(DEPTH));
endmodule

// File: tb/tb_toy_fe_update_queue.sv
// Directed + random scoreboard bench for the frontend update queue.
module tb_toy_fe_update_queue;
  import toy_fe_update_queue_pkg::*;

  localparam int CH = FE_UPQ_CHNL_NUM;
  localparam int DP = FE_UPQ_DEPTH;
  localparam int RD = FE_UPQ_RD_NUM;
  localparam int PW = $bits(be_pkg_t);

  typedef struct packed {
    logic [PW-1:0] pld;
    logic          canc;
  } exp_t;

  logic clk = 1'b0;
  logic rst, flush;
  logic [$clog2(DP):0] count;
  exp_t sb[$];
  logic pend;
  int errs = 0;
  int checks = 0;
  logic [PW-1:0] seq = 24'h100000;

  always #5 clk = ~clk;

  toy_fe_update_queue_if #(.CHNL_NUM(CH), .RD_NUM(RD), .PLD_WIDTH(PW)) bus();

  toy_fe_update_queue #(.CHNL_NUM(CH), .DEPTH(DP), .RD_NUM(RD), .PLD_WIDTH(PW)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .count_o (count),
    .bus_if  (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [CH-1:0] v, input logic [CH-1:0] l, input logic c);
    bus.in_vld    = v;
    bus.in_last   = l;
    bus.in_cancel = c;
    for (int i = 0; i < CH; i++) begin
      bus.in_pld[i] = seq;
      seq = seq + 1;
    end
  endtask

  // Compare visible lanes against the scoreboard, update the model, then advance one clock.
  task automatic tick();
    int sz, vis, pops;
    logic [CH-1:0] en;
    logic acc;
    exp_t e;
    sz  = sb.size();
    vis = (sz < RD) ? sz : RD;
    chk("out_vld", 64'(bus.out_vld), (64'd1 << vis) - 64'd1);
    chk("in_rdy", 64'(bus.in_rdy), 64'((DP - sz) >= CH));
    for (int k = 0; k < vis; k++) begin
      chk("out_pld", 64'(bus.out_pld[k]), 64'(sb[k].pld));
      chk("out_cancel", 64'(bus.out_cancel[k]), 64'(sb[k].canc));
    end
    pops = 0;
    for (int k = 0; k < vis; k++) if (pops == k && bus.out_rdy[k]) pops++;
    en  = bus.in_vld & bus.in_last;
    acc = !rst && !flush && ((DP - sz) >= CH) && (en != '0);
    if (rst || flush) begin
      sb.delete();
      pend = 1'b0;
    end else begin
      for (int k = 0; k < pops; k++) void'(sb.pop_front());
      if (acc) begin
        for (int i = 0; i < CH; i++)
          if (en[i]) begin
            e.pld  = bus.in_pld[i];
            e.canc = 1'b0;
            sb.push_back(e);
          end
        e = sb.pop_back();
        e.canc = bus.in_cancel | pend;
        sb.push_back(e);
        pend = 1'b0;
      end else begin
        if (pend && sz > 0) begin
          if (pops < sz) begin
            e = sb.pop_back();
            e.canc = 1'b1;
            sb.push_back(e);
          end
          pend = 1'b0;
        end
        if (bus.in_cancel && en == '0) pend = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("count", 64'(count), 64'(sb.size()));
  endtask

  task automatic drain();
    bus.out_rdy = '1;
    drive('0, '0, 1'b0);
    for (int g = 0; g < 40 && sb.size() > 0; g++) tick();
    chk("drained", 64'(count), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    pend = 1'b0;
    bus.out_rdy = '0;
    drive('0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_vld", 64'(bus.out_vld), 64'd0);
    chk("rst_in_rdy", 64'(bus.in_rdy), 64'd1);

    // compaction: channels 1 and 3 only
    drive(4'b1111, 4'b1010, 1'b0);
    tick();
    drive('0, '0, 1'b0);
    chk("cmp_count", 64'(count), 64'd2);
    chk("cmp_vld", 64'(bus.out_vld), 64'b11);
    chk("cmp_lane0", 64'(bus.out_pld[0]), 64'(seq - 24'd7));
    chk("cmp_lane1", 64'(bus.out_pld[1]), 64'(seq - 24'd5));
    tick();
    drain();

    // cancel attached to the youngest of a 3-entry group
    drive(4'b1111, 4'b0111, 1'b1);
    tick();
    drive('0, '0, 1'b0);
    chk("canc_first2", 64'(bus.out_cancel), 64'b00);
    drain();

    // pending cancel on an empty queue
    drive(4'b0001, 4'b0000, 1'b1);
    tick();
    drive(4'b0001, 4'b0001, 1'b0);
    tick();
    drive('0, '0, 1'b0);
    chk("pend_applied", 64'(bus.out_cancel), 64'b01);
    drive(4'b0001, 4'b0001, 1'b0);
    tick();
    drain();

    // fill to full, hold a group under backpressure
    bus.out_rdy = '0;
    for (int g = 0; g < 4; g++) begin
      drive(4'b1111, 4'b1111, 1'b0);
      tick();
    end
    chk("full_count", 64'(count), 64'd16);
    chk("full_rdy", 64'(bus.in_rdy), 64'd0);
    drive(4'b1111, 4'b1111, 1'b0);
    bus.out_rdy = 2'b11;
    tick();
    tick();
    bus.out_rdy = '0;
    chk("hold_rdy12", 64'(bus.in_rdy), 64'd1);
    tick();
    drive('0, '0, 1'b0);
    chk("hold_accept", 64'(count), 64'd16);
    bus.out_rdy = 2'b01;
    repeat (3) tick();
    chk("cnt13_rdy", 64'(bus.in_rdy), 64'd0);
    drain();

    // random last bits across pointer wrap
    bus.out_rdy = 2'b11;
    for (int g = 0; g < 40; g++) begin
      drive(4'b0111, CH'($urandom), 1'b0);
      tick();
      chk("cnt_bound", 64'(count <= 16), 64'd1);
    end
    drain();

    // flush with a concurrent push, then the same with reset
    for (int r = 0; r < 2; r++) begin
      bus.out_rdy = '0;
      drive(4'b1111, 4'b1111, 1'b0);
      tick();
      drive(4'b0111, 4'b0111, 1'b0);
      tick();
      chk("pre_clr_cnt", 64'(count), 64'd7);
      drive(4'b1111, 4'b1111, 1'b0);
      if (r == 0) flush = 1'b1; else rst = 1'b1;
      tick();
      flush = 1'b0;
      rst = 1'b0;
      drive('0, '0, 1'b0);
      chk("clr_count", 64'(count), 64'd0);
      chk("clr_out_vld", 64'(bus.out_vld), 64'd0);
      chk("clr_in_rdy", 64'(bus.in_rdy), 64'd1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
